// File: rtl/pe_wq.sv
// Systolic-array PE: registered MAC (psum_out = in * w_active + psum_in) with a
// W_DEPTH-entry weight queue fed by the w_in/w_out load chain.
module pe_wq #(
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_WIDTH = 2 * DATA_WIDTH,
    parameter int W_DEPTH    = 4,
    parameter int SIGNED     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_in,
    input  logic [DATA_WIDTH-1:0]         in,
    input  logic [PSUM_WIDTH-1:0]         psum_in,
    input  logic                          sat_en,
    input  logic                          w_load_in,
    input  logic                          w_wen_in,
    input  logic [DATA_WIDTH-1:0]         w_in,
    input  logic                          w_adv,
    input  logic                          w_flush,
    output logic                          en_out,
    output logic [DATA_WIDTH-1:0]         pass_out,
    output logic [PSUM_WIDTH-1:0]         psum_out,
    output logic                          w_wen_out,
    output logic [DATA_WIDTH-1:0]         w_out,
    output logic                          w_active_valid,
    output logic [$clog2(W_DEPTH+1)-1:0]  w_count,
    output logic                          w_full,
    output logic                          w_ovf
);

    localparam int CW   = $clog2(W_DEPTH + 1);
    localparam int PTRW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int PRW  = 2 * DATA_WIDTH;

    logic                  en_q, en_d;
    logic [DATA_WIDTH-1:0] pass_q, pass_d;
    logic [PSUM_WIDTH-1:0] psum_q, psum_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wout_q, wout_d;
    logic [DATA_WIDTH-1:0] act_q, act_d;
    logic                  act_valid_q, act_valid_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PTRW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic                  ovf_q, ovf_d;
    logic                  prev_load_q, prev_load_d;
    logic [DATA_WIDTH-1:0] mem_q [W_DEPTH];

    logic                  full, push_req, do_push, do_pop, load_done;
    logic [PRW-1:0]        prod_u;
    logic signed [PRW-1:0] prod_s;
    logic [PSUM_WIDTH:0]   prod_ext, psum_ext, sum;
    logic [PSUM_WIDTH-1:0] mac_res;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(W_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (cnt_q == CW'(W_DEPTH));
    assign push_req  = w_load_in & w_wen_in;
    assign load_done = prev_load_q & ~w_load_in;
    assign do_push   = push_req & ~full & ~w_flush;
    assign do_pop    = ~w_flush & (cnt_q != '0) &
                       (w_adv | (load_done & ~act_valid_q));

    // Widen first so the product is formed at 2*DATA_WIDTH in the right signedness.
    assign prod_u = PRW'(in) * PRW'(act_q);
    assign prod_s = PRW'($signed(in)) * PRW'($signed(act_q));

    always_comb begin
        prod_ext = '0;
        psum_ext = '0;
        mac_res  = '0;
        if (SIGNED != 0) begin
            prod_ext = (PSUM_WIDTH+1)'(prod_s);
            psum_ext = (PSUM_WIDTH+1)'($signed(psum_in));
        end else begin
            prod_ext = (PSUM_WIDTH+1)'(prod_u);
            psum_ext = (PSUM_WIDTH+1)'(psum_in);
        end
        sum     = prod_ext + psum_ext;
        mac_res = sum[PSUM_WIDTH-1:0];
        if (sat_en) begin
            if (SIGNED != 0) begin
                // The extra top bit is the true sign; disagreement with the MSB means overflow.
                if (sum[PSUM_WIDTH] != sum[PSUM_WIDTH-1])
                    mac_res = sum[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                              : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
            end else if (sum[PSUM_WIDTH]) begin
                mac_res = '1;
            end
        end
    end

    always_comb begin
        en_d        = en_in;
        pass_d      = pass_q;
        psum_d      = psum_q;
        wen_d       = w_wen_in;
        wout_d      = push_req ? w_in : '0;
        act_d       = act_q;
        act_valid_d = act_valid_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        ovf_d       = ovf_q;
        prev_load_d = w_load_in;

        if (en_in) begin
            pass_d = in;
            psum_d = mac_res;
        end

        if (w_flush) begin
            act_d       = '0;
            act_valid_d = 1'b0;
            cnt_d       = '0;
            rd_d        = '0;
            wr_d        = '0;
            ovf_d       = 1'b0;
        end else begin
            if (do_pop) begin
                act_d       = mem_q[rd_q];
                act_valid_d = 1'b1;
                rd_d        = ptr_inc(rd_q);
            end else if (w_adv) begin
                act_d       = '0;
                act_valid_d = 1'b0;
            end
            if (do_push)
                wr_d = ptr_inc(wr_q);
            if (push_req & full)
                ovf_d = 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            pass_q      <= '0;
            psum_q      <= '0;
            wen_q       <= 1'b0;
            wout_q      <= '0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            ovf_q       <= 1'b0;
            prev_load_q <= 1'b0;
        end else begin
            en_q        <= en_d;
            pass_q      <= pass_d;
            psum_q      <= psum_d;
            wen_q       <= wen_d;
            wout_q      <= wout_d;
            act_q       <= act_d;
            act_valid_q <= act_valid_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ovf_q       <= ovf_d;
            prev_load_q <= prev_load_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked solely by cnt_q.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem_q[wr_q] <= w_in;
    end

    assign en_out         = en_q;
    assign pass_out       = pass_q;
    assign psum_out       = psum_q;
    assign w_wen_out      = wen_q;
    assign w_out          = wout_q;
    assign w_active_valid = act_valid_q;
    assign w_count        = cnt_q;
    assign w_full         = full;
    assign w_ovf          = ovf_q;

endmodule

// File: tb/tb_pe_wq.sv
// Directed bench for pe_wq: an unsigned and a signed instance (DATA_WIDTH=8,
// PSUM_WIDTH=16, W_DEPTH=4) share all inputs.
module tb_pe_wq;

    logic        clk = 1'b0;
    logic        rst, en_in, sat_en, w_load_in, w_wen_in, w_adv, w_flush;
    logic [7:0]  in, w_in;
    logic [15:0] psum_in;

    logic        u_en, u_wen, u_valid, u_full, u_ovf;
    logic [7:0]  u_pass, u_wout;
    logic [15:0] u_psum;
    logic [2:0]  u_cnt;
    logic        s_en, s_wen, s_valid, s_full, s_ovf;
    logic [7:0]  s_pass, s_wout;
    logic [15:0] s_psum;
    logic [2:0]  s_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pe_wq #(.DATA_WIDTH(8), .PSUM_WIDTH(16), .W_DEPTH(4), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .en_in(en_in), .in(in), .psum_in(psum_in),
        .sat_en(sat_en), .w_load_in(w_load_in), .w_wen_in(w_wen_in), .w_in(w_in),
        .w_adv(w_adv), .w_flush(w_flush), .en_out(u_en), .pass_out(u_pass),
        .psum_out(u_psum), .w_wen_out(u_wen), .w_out(u_wout),
        .w_active_valid(u_valid), .w_count(u_cnt), .w_full(u_full), .w_ovf(u_ovf));

    pe_wq #(.DATA_WIDTH(8), .PSUM_WIDTH(16), .W_DEPTH(4), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .en_in(en_in), .in(in), .psum_in(psum_in),
        .sat_en(sat_en), .w_load_in(w_load_in), .w_wen_in(w_wen_in), .w_in(w_in),
        .w_adv(w_adv), .w_flush(w_flush), .en_out(s_en), .pass_out(s_pass),
        .psum_out(s_psum), .w_wen_out(s_wen), .w_out(s_wout),
        .w_active_valid(s_valid), .w_count(s_cnt), .w_full(s_full), .w_ovf(s_ovf));

    typedef struct {
        logic        en;
        logic [7:0]  a;
        logic [15:0] p;
        logic        sat;
        logic [15:0] exp_u;
        logic [15:0] exp_s;
        logic [7:0]  exp_pass;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        w_load_in = 1'b1;
        w_wen_in  = 1'b1;
        w_in      = v;
        tick();
        w_wen_in  = 1'b0;
        w_in      = '0;
    endtask

    task automatic end_window();
        w_load_in = 1'b0;
        tick();
    endtask

    task automatic adv();
        w_adv = 1'b1;
        tick();
        w_adv = 1'b0;
    endtask

    task automatic flush();
        w_flush = 1'b1;
        tick();
        w_flush = 1'b0;
    endtask

    task automatic mac(input logic [7:0] a, input logic [15:0] p, input logic sat);
        en_in   = 1'b1;
        in      = a;
        psum_in = p;
        sat_en  = sat;
        tick();
        en_in   = 1'b0;
    endtask

    initial begin
        // Active weight 0xFE: 254 unsigned, -2 signed.
        vecs[0] = '{1'b1, 8'h03, 16'h000A, 1'b0, 16'h0304, 16'h0004, 8'h03};
        vecs[1] = '{1'b1, 8'hFF, 16'h0000, 1'b0, 16'hFD02, 16'h0002, 8'hFF};
        vecs[2] = '{1'b1, 8'hFF, 16'h1000, 1'b1, 16'hFFFF, 16'h1002, 8'hFF};
        vecs[3] = '{1'b1, 8'hFF, 16'h1000, 1'b0, 16'h0D02, 16'h1002, 8'hFF};
        vecs[4] = '{1'b1, 8'h80, 16'h8000, 1'b1, 16'hFF00, 16'h8100, 8'h80};
        vecs[5] = '{1'b1, 8'h7F, 16'h8000, 1'b1, 16'hFE02, 16'h8000, 8'h7F};
        vecs[6] = '{1'b1, 8'h7F, 16'h8000, 1'b0, 16'hFE02, 16'h7F02, 8'h7F};
        vecs[7] = '{1'b0, 8'h11, 16'h1234, 1'b1, 16'hFE02, 16'h7F02, 8'h7F};

        rst = 1'b1; en_in = 1'b0; in = '0; psum_in = '0; sat_en = 1'b0;
        w_load_in = 1'b0; w_wen_in = 1'b0; w_in = '0; w_adv = 1'b0; w_flush = 1'b0;
        tick();
        tick();
        chk("rst_psum", u_psum, 16'h0);
        chk("rst_valid", u_valid, 1'b0);
        chk("rst_cnt", s_cnt, 3'd0);
        rst = 1'b0;

        // Single weight commit at window end, then MAC.
        push(8'd3);
        chk("t1_wout", u_wout, 8'd3);
        chk("t1_wen_out", u_wen, 1'b1);
        chk("t1_valid_before_end", u_valid, 1'b0);
        end_window();
        chk("t1_valid", u_valid, 1'b1);
        chk("t1_cnt", u_cnt, 3'd0);
        mac(8'd5, 16'd7, 1'b0);
        chk("t1_psum_u", u_psum, 16'd22);
        chk("t1_psum_s", s_psum, 16'd22);
        chk("t1_pass", u_pass, 8'd5);
        chk("t1_en_out", u_en, 1'b1);
        tick();
        chk("t1_en_out_low", u_en, 1'b0);

        // Overfill, commit, then drain with w_adv.
        flush();
        chk("t2_flush_valid", u_valid, 1'b0);
        push(8'd1); push(8'd2); push(8'd3); push(8'd4);
        chk("t2_full", u_full, 1'b1);
        chk("t2_ovf_pre", u_ovf, 1'b0);
        push(8'd5);
        chk("t2_ovf", u_ovf, 1'b1);
        chk("t2_cnt_full", u_cnt, 3'd4);
        chk("t2_wout_drop", u_wout, 8'd5);
        end_window();
        chk("t2_cnt_commit", u_cnt, 3'd3);
        chk("t2_full_commit", u_full, 1'b0);
        mac(8'd1, 16'd0, 1'b0);
        chk("t2_w1", u_psum, 16'd1);
        for (int k = 2; k <= 4; k++) begin
            adv();
            mac(8'd1, 16'd0, 1'b0);
            chk($sformatf("t2_w%0d", k), u_psum, 16'(k));
        end
        chk("t2_cnt_empty", u_cnt, 3'd0);
        adv();
        chk("t2_valid_drain", u_valid, 1'b0);
        mac(8'd1, 16'd0, 1'b0);
        chk("t2_w_zero", u_psum, 16'd0);

        // Table-driven MAC vectors with weight 0xFE.
        push(8'hFE);
        end_window();
        for (int i = 0; i < 8; i++) begin
            en_in = vecs[i].en; in = vecs[i].a; psum_in = vecs[i].p; sat_en = vecs[i].sat;
            tick();
            chk($sformatf("vec%0d_psum_u", i), u_psum, vecs[i].exp_u);
            chk($sformatf("vec%0d_psum_s", i), s_psum, vecs[i].exp_s);
            chk($sformatf("vec%0d_pass", i), s_pass, vecs[i].exp_pass);
            chk($sformatf("vec%0d_en_out", i), s_en, vecs[i].en);
        end
        en_in = 1'b0;

        // Signed saturation at the positive limit; wrap when saturation is off.
        adv();
        push(8'd127);
        end_window();
        mac(8'd127, 16'h7FFF, 1'b1);
        chk("t3_sat_s", s_psum, 16'h7FFF);
        chk("t3_sat_u", u_psum, 16'hBF00);
        mac(8'd127, 16'h7FFF, 1'b0);
        chk("t3_wrap_s", s_psum, 16'hBF00);

        // Pop and push in the same cycle; flush with a concurrent push.
        adv();
        push(8'd6); push(8'd7); push(8'd8);
        end_window();
        chk("t5_cnt2", u_cnt, 3'd2);
        w_load_in = 1'b1; w_wen_in = 1'b1; w_in = 8'd9; w_adv = 1'b1;
        tick();
        w_wen_in = 1'b0; w_adv = 1'b0;
        chk("t5_cnt_pushpop", u_cnt, 3'd2);
        end_window();
        chk("t5_cnt_after_end", u_cnt, 3'd2);
        chk("t5_valid", u_valid, 1'b1);
        mac(8'd1, 16'd0, 1'b0);
        chk("t5_w7", u_psum, 16'd7);
        chk("t5_ovf_sticky", u_ovf, 1'b1);
        w_load_in = 1'b1; w_wen_in = 1'b1; w_in = 8'h5A; w_flush = 1'b1;
        tick();
        w_wen_in = 1'b0; w_flush = 1'b0;
        chk("t5_flush_cnt", u_cnt, 3'd0);
        chk("t5_flush_valid", u_valid, 1'b0);
        chk("t5_flush_ovf", u_ovf, 1'b0);
        chk("t5_flush_wout", u_wout, 8'h5A);
        end_window();
        chk("t5_no_commit", s_valid, 1'b0);

        // Reset mid-load and mid-MAC.
        push(8'd1); push(8'd2);
        chk("t6_cnt_pre", u_cnt, 3'd2);
        rst = 1'b1; w_load_in = 1'b1; w_wen_in = 1'b1; w_in = 8'd3;
        en_in = 1'b1; in = 8'd9; psum_in = 16'd5;
        tick();
        rst = 1'b0; w_wen_in = 1'b0; w_in = '0; en_in = 1'b0;
        chk("t6_en", u_en, 1'b0);
        chk("t6_pass", u_pass, 8'd0);
        chk("t6_psum", s_psum, 16'd0);
        chk("t6_wen", u_wen, 1'b0);
        chk("t6_wout", u_wout, 8'd0);
        chk("t6_cnt", u_cnt, 3'd0);
        chk("t6_full", u_full, 1'b0);
        chk("t6_ovf", u_ovf, 1'b0);
        tick();
        end_window();
        chk("t6_valid", u_valid, 1'b0);
        mac(8'd1, 16'h0021, 1'b0);
        chk("t6_passthru", u_psum, 16'h0021);

        // Advance with a push into an empty queue, then commit at window end.
        push(8'h44);
        end_window();
        w_load_in = 1'b1; w_wen_in = 1'b1; w_in = 8'h33; w_adv = 1'b1;
        tick();
        w_wen_in = 1'b0; w_adv = 1'b0;
        chk("t7_valid_cleared", u_valid, 1'b0);
        chk("t7_cnt1", u_cnt, 3'd1);
        end_window();
        chk("t7_valid_commit", u_valid, 1'b1);
        chk("t7_cnt0", u_cnt, 3'd0);
        mac(8'd2, 16'd1, 1'b0);
        chk("t7_psum_u", u_psum, 16'h0067);
        chk("t7_psum_s", s_psum, 16'h0067);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
